// File: rtl/combo_event_sequencer_if.sv
// Handshake bundle between the mole-grid request logic and the combo event sequencer.
// With COMBO_STATS_EN defined the bundle also carries the hit/miss statistics counters.
interface combo_event_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          game_active;
  logic                          hit_req;
  logic                          full_clear;
  logic                          miss_req;
  logic                          miss;
  logic                          non_full_clear_hit;
  logic                          full_clear_hit;
  logic                          busy;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   queue_level;
`ifdef COMBO_STATS_EN
  logic [7:0]                    hit_count;
  logic [7:0]                    miss_count;

  modport master (
    output game_active, hit_req, full_clear, miss_req,
    input  miss, non_full_clear_hit, full_clear_hit, busy, overflow, queue_level,
    input  hit_count, miss_count
  );

  modport slave (
    input  game_active, hit_req, full_clear, miss_req,
    output miss, non_full_clear_hit, full_clear_hit, busy, overflow, queue_level,
    output hit_count, miss_count
  );
`else
  modport master (
    output game_active, hit_req, full_clear, miss_req,
    input  miss, non_full_clear_hit, full_clear_hit, busy, overflow, queue_level
  );

  modport slave (
    input  game_active, hit_req, full_clear, miss_req,
    output miss, non_full_clear_hit, full_clear_hit, busy, overflow, queue_level
  );
`endif
endinterface

// File: rtl/combo_event_sequencer.sv
// Edge-detects hit/miss requests, queues them and replays them as exclusive one-cycle pulses
// for the combo counter. COMBO_STATS_EN adds saturating hit_count/miss_count outputs.
module combo_event_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  combo_event_sequencer_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

  localparam logic [1:0] EV_NFC  = 2'b01;
  localparam logic [1:0] EV_FC   = 2'b10;
  localparam logic [1:0] EV_MISS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [GW-1:0]   gap_cnt_r;

  logic            hit_q_r;
  logic            miss_q_r;
  logic [1:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            hit_ev_s;
  logic            miss_ev_s;
  logic [1:0]      hit_code_s;
  logic            has_entry_s;
  logic            pop_s;
  logic [CW-1:0]   avail_s;
  logic            wr_hit_s;
  logic            wr_miss_s;
  logic            drop_s;
  logic [CW-1:0]   count_nxt_s;

  logic [1:0]      pulse_code_s;
  logic            miss_d_s;
  logic            nfc_d_s;
  logic            fc_d_s;
  logic            busy_d_s;

  logic            miss_r;
  logic            nfc_r;
  logic            fc_r;
  logic            busy_r;
  logic            overflow_r;

  assign has_entry_s = (count_r != {CW{1'b0}});
  assign pop_s       = (next_state_s == ST_ISSUE);

  // FSM state register and gap counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
      end else begin
        gap_cnt_r <= {GW{1'b0}};
      end
    end
  end

  // Next-state logic; the last gap cycle hands straight to ISSUE so the gap is exactly GAP_CYCLES
  always_comb begin
    next_state_s = ST_IDLE;
    if (!bus.game_active) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (has_entry_s) next_state_s = ST_ISSUE;
          else             next_state_s = ST_IDLE;
        end
        ST_ISSUE: begin
          if (HAS_GAP)          next_state_s = ST_GAP;
          else if (has_entry_s) next_state_s = ST_ISSUE;
          else                  next_state_s = ST_IDLE;
        end
        ST_GAP: begin
          if (gap_cnt_r != GAP_LAST) next_state_s = ST_GAP;
          else if (has_entry_s)      next_state_s = ST_ISSUE;
          else                       next_state_s = ST_IDLE;
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Edge detection and enqueue arbitration: hit takes the first free slot, miss the second
  always_comb begin
    hit_ev_s   = bus.hit_req & ~hit_q_r;
    miss_ev_s  = bus.miss_req & ~miss_q_r;
    if (bus.full_clear) hit_code_s = EV_FC;
    else                hit_code_s = EV_NFC;
    avail_s    = DEPTH_C - count_r + CW'(pop_s);
    wr_hit_s   = bus.game_active & hit_ev_s & (avail_s != {CW{1'b0}});
    wr_miss_s  = bus.game_active & miss_ev_s & (avail_s > CW'(wr_hit_s));
    drop_s     = bus.game_active & ((hit_ev_s & ~wr_hit_s) | (miss_ev_s & ~wr_miss_s));
    if (bus.game_active) begin
      count_nxt_s = count_r + CW'(wr_hit_s) + CW'(wr_miss_s) - CW'(pop_s);
    end else begin
      count_nxt_s = {CW{1'b0}};
    end
  end

  // Output decode: pulses are computed for the cycle the FSM enters ISSUE
  always_comb begin
    if (pop_s) pulse_code_s = mem_r[rd_ptr_r];
    else       pulse_code_s = 2'b00;
    miss_d_s = (pulse_code_s == EV_MISS);
    nfc_d_s  = (pulse_code_s == EV_NFC);
    fc_d_s   = (pulse_code_s == EV_FC);
    busy_d_s = (count_nxt_s != {CW{1'b0}}) | (next_state_s != ST_IDLE);
  end

  // Request edge registers keep tracking even while the game is inactive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q_r  <= 1'b0;
      miss_q_r <= 1'b0;
    end else begin
      hit_q_r  <= bus.hit_req;
      miss_q_r <= bus.miss_req;
    end
  end

  // Event queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 2'b00;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (!bus.game_active) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_hit_s)  mem_r[wr_ptr_r] <= hit_code_s;
      if (wr_miss_s) mem_r[wr_ptr_r + AW'(wr_hit_s)] <= EV_MISS;
      wr_ptr_r <= wr_ptr_r + AW'(wr_hit_s) + AW'(wr_miss_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_nxt_s;
    end
  end

  // Registered pulse, busy and sticky overflow outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_r     <= 1'b0;
      nfc_r      <= 1'b0;
      fc_r       <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      miss_r     <= miss_d_s;
      nfc_r      <= nfc_d_s;
      fc_r       <= fc_d_s;
      busy_r     <= busy_d_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign bus.miss               = miss_r;
  assign bus.non_full_clear_hit = nfc_r;
  assign bus.full_clear_hit     = fc_r;
  assign bus.busy               = busy_r;
  assign bus.overflow           = overflow_r;
  assign bus.queue_level        = count_r;

`ifdef COMBO_STATS_EN
  logic [7:0] hit_cnt_r;
  logic [7:0] miss_cnt_r;

  // Saturating statistics counters, cleared whenever the game is inactive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_r  <= 8'd0;
      miss_cnt_r <= 8'd0;
    end else if (!bus.game_active) begin
      hit_cnt_r  <= 8'd0;
      miss_cnt_r <= 8'd0;
    end else begin
      if ((nfc_d_s | fc_d_s) && (hit_cnt_r != 8'hFF)) hit_cnt_r <= hit_cnt_r + 8'd1;
      if (miss_d_s && (miss_cnt_r != 8'hFF))          miss_cnt_r <= miss_cnt_r + 8'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_r;
  assign bus.miss_count = miss_cnt_r;
`endif

endmodule

// File: tb/tb_combo_event_sequencer.sv
// Directed self-checking bench for combo_event_sequencer: one instance with GAP_CYCLES=1,
// one with GAP_CYCLES=3 for the queue-overflow scenario.
module tb_combo_event_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks_n = 0;
  int   errors_n = 0;
  int   a_nfc_n, a_fc_n, a_miss_n;
  int   b_nfc_n, b_fc_n, b_miss_n, b_peak;

  combo_event_sequencer_if #(.FIFO_DEPTH(4)) if_a ();
  combo_event_sequencer_if #(.FIFO_DEPTH(4)) if_b ();

  combo_event_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  combo_event_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    a_nfc_n = 0; a_fc_n = 0; a_miss_n = 0;
    b_nfc_n = 0; b_fc_n = 0; b_miss_n = 0; b_peak = 0;
  endtask

  // One clock; sample 1 time unit after the rising edge and accumulate pulses
  task automatic step();
    @(posedge clk);
    #1;
    a_nfc_n  += int'(if_a.non_full_clear_hit);
    a_fc_n   += int'(if_a.full_clear_hit);
    a_miss_n += int'(if_a.miss);
    b_nfc_n  += int'(if_b.non_full_clear_hit);
    b_fc_n   += int'(if_b.full_clear_hit);
    b_miss_n += int'(if_b.miss);
    if (int'(if_b.queue_level) > b_peak) b_peak = int'(if_b.queue_level);
    check_eq("onehot_a", ($countones({if_a.miss, if_a.non_full_clear_hit, if_a.full_clear_hit}) > 1) ? 32'd1 : 32'd0, 32'd0);
    check_eq("onehot_b", ($countones({if_b.miss, if_b.non_full_clear_hit, if_b.full_clear_hit}) > 1) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    if_a.game_active = 1'b1; if_a.hit_req = 1'b0; if_a.full_clear = 1'b0; if_a.miss_req = 1'b0;
    if_b.game_active = 1'b1; if_b.hit_req = 1'b0; if_b.full_clear = 1'b0; if_b.miss_req = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_pulses", {29'd0, if_a.miss, if_a.non_full_clear_hit, if_a.full_clear_hit}, 32'd0);
    check_eq("reset_busy_ovf", {30'd0, if_a.busy, if_a.overflow}, 32'd0);
    check_eq("reset_level", {29'd0, if_a.queue_level}, 32'd0);
    reset_n = 1'b1;
    step();

    // single NFC hit: queued at edge k, pulse after edge k+1
    clear_counts();
    if_a.hit_req = 1'b1;
    step();
    check_eq("t1_level_k", {29'd0, if_a.queue_level}, 32'd1);
    check_eq("t1_nfc_k", {31'd0, if_a.non_full_clear_hit}, 32'd0);
    check_eq("t1_busy_k", {31'd0, if_a.busy}, 32'd1);
    if_a.hit_req = 1'b0;
    step();
    check_eq("t1_nfc_k1", {31'd0, if_a.non_full_clear_hit}, 32'd1);
    check_eq("t1_others_k1", {30'd0, if_a.miss, if_a.full_clear_hit}, 32'd0);
    check_eq("t1_level_k1", {29'd0, if_a.queue_level}, 32'd0);
    step();
    check_eq("t1_nfc_k2", {31'd0, if_a.non_full_clear_hit}, 32'd0);
    step();
    check_eq("t1_idle", {31'd0, if_a.busy}, 32'd0);
    check_eq("t1_count", a_nfc_n, 32'd1);

    // held hit level with full_clear fires once
    clear_counts();
    if_a.hit_req = 1'b1; if_a.full_clear = 1'b1;
    repeat (40) step();
    if_a.hit_req = 1'b0; if_a.full_clear = 1'b0;
    repeat (4) step();
    check_eq("t2_fc_count", a_fc_n, 32'd1);
    check_eq("t2_other_count", a_nfc_n + a_miss_n, 32'd0);

    // simultaneous hit + miss: hit, one idle cycle, miss
    clear_counts();
    if_a.hit_req = 1'b1; if_a.miss_req = 1'b1;
    step();
    check_eq("t3_level", {29'd0, if_a.queue_level}, 32'd2);
    if_a.hit_req = 1'b0; if_a.miss_req = 1'b0;
    step();
    check_eq("t3_first_nfc", {30'd0, if_a.non_full_clear_hit, if_a.miss}, 32'd2);
    step();
    check_eq("t3_gap", {29'd0, if_a.miss, if_a.non_full_clear_hit, if_a.full_clear_hit}, 32'd0);
    step();
    check_eq("t3_second_miss", {30'd0, if_a.non_full_clear_hit, if_a.miss}, 32'd1);
    repeat (3) step();
    check_eq("t3_idle", {31'd0, if_a.busy}, 32'd0);

    // GAP_CYCLES=3: three hit+miss pairs, last miss dropped
    clear_counts();
    if_b.hit_req = 1'b1; if_b.miss_req = 1'b1;
    step();
    check_eq("t4_level_k", {29'd0, if_b.queue_level}, 32'd2);
    if_b.hit_req = 1'b0; if_b.miss_req = 1'b0;
    step();
    check_eq("t4_nfc_k1", {31'd0, if_b.non_full_clear_hit}, 32'd1);
    if_b.hit_req = 1'b1; if_b.miss_req = 1'b1;
    step();
    check_eq("t4_level_k2", {29'd0, if_b.queue_level}, 32'd3);
    if_b.hit_req = 1'b0; if_b.miss_req = 1'b0;
    step();
    check_eq("t4_ovf_k3", {31'd0, if_b.overflow}, 32'd0);
    if_b.hit_req = 1'b1; if_b.miss_req = 1'b1;
    step();
    check_eq("t4_level_k4", {29'd0, if_b.queue_level}, 32'd4);
    check_eq("t4_ovf_k4", {31'd0, if_b.overflow}, 32'd1);
    if_b.hit_req = 1'b0; if_b.miss_req = 1'b0;
    repeat (25) step();
    check_eq("t4_nfc_total", b_nfc_n, 32'd3);
    check_eq("t4_miss_total", b_miss_n, 32'd2);
    check_eq("t4_fc_total", b_fc_n, 32'd0);
    check_eq("t4_peak", b_peak, 32'd4);
    check_eq("t4_level_end", {29'd0, if_b.queue_level}, 32'd0);
    check_eq("t4_ovf_sticky", {31'd0, if_b.overflow}, 32'd1);

    // flush with 3 queued, levels held across re-enable stay silent
    if_a.hit_req = 1'b1; if_a.miss_req = 1'b1;
    step();
    if_a.hit_req = 1'b0; if_a.miss_req = 1'b0;
    step();
    if_a.hit_req = 1'b1; if_a.miss_req = 1'b1;
    step();
    check_eq("t5_level_3", {29'd0, if_a.queue_level}, 32'd3);
    clear_counts();
    if_a.game_active = 1'b0;
    step();
    check_eq("t5_level_flush", {29'd0, if_a.queue_level}, 32'd0);
    check_eq("t5_busy_flush", {31'd0, if_a.busy}, 32'd0);
    repeat (5) step();
    if_a.game_active = 1'b1;
    repeat (10) step();
    if_a.hit_req = 1'b0; if_a.miss_req = 1'b0;
    repeat (3) step();
    check_eq("t5_silent", a_nfc_n + a_fc_n + a_miss_n, 32'd0);
    check_eq("t5_level_end", {29'd0, if_a.queue_level}, 32'd0);
    check_eq("t5_ovf", {31'd0, if_a.overflow}, 32'd0);

    // reset in the middle of a pulse with one event still queued
    if_a.hit_req = 1'b1; if_a.miss_req = 1'b1; if_a.full_clear = 1'b1;
    step();
    if_a.hit_req = 1'b0; if_a.miss_req = 1'b0; if_a.full_clear = 1'b0;
    step();
    check_eq("t6_fc_pulse", {31'd0, if_a.full_clear_hit}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_pulse_cut", {29'd0, if_a.miss, if_a.non_full_clear_hit, if_a.full_clear_hit}, 32'd0);
    check_eq("t6_level", {29'd0, if_a.queue_level}, 32'd0);
    check_eq("t6_busy", {31'd0, if_a.busy}, 32'd0);
    check_eq("t6_ovf_b", {31'd0, if_b.overflow}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_counts();
    repeat (8) step();
    check_eq("t6_no_replay", a_nfc_n + a_fc_n + a_miss_n, 32'd0);
    check_eq("t6_level_end", {29'd0, if_a.queue_level}, 32'd0);

`ifdef COMBO_STATS_EN
    // statistics: NFC hit, FC hit, NFC hit, miss
    for (int i = 0; i < 4; i++) begin
      if_a.full_clear = (i == 1);
      if (i == 3) if_a.miss_req = 1'b1;
      else        if_a.hit_req  = 1'b1;
      step();
      if_a.hit_req = 1'b0; if_a.miss_req = 1'b0; if_a.full_clear = 1'b0;
      repeat (4) step();
    end
    check_eq("stats_hit", {24'd0, if_a.hit_count}, 32'd3);
    check_eq("stats_miss", {24'd0, if_a.miss_count}, 32'd1);
    if_a.game_active = 1'b0;
    step();
    check_eq("stats_clear", {16'd0, if_a.hit_count, if_a.miss_count}, 32'd0);
    if_a.game_active = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
